// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch resolve, handshaked data memory access, MEM/WB registers
module mem_stage #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] outE,
    input  logic              oZeroD,
    input  logic [DATA_W-1:0] data2D_E,
    input  logic [DATA_W-1:0] RegEscr1E,
    input  logic [DATA_W-1:0] salSum2E,
    input  logic              ctl_branch,
    input  logic              ctl_mem_read,
    input  logic              ctl_mem_write,
    input  logic              ctl_reg_write,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] wb_reg,
    output logic              misalign,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR    = 2'd2;
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_wait;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_is_load;
    logic              r_rw;
    logic [DATA_W-1:0] r_reg;
    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_wb_reg;
    logic              r_pc_src;
    logic [DATA_W-1:0] r_branch_target;
    logic              r_misalign;
    logic              r_bus_err;

    logic w_accept;
    logic w_is_mem;
    logic w_misal;
    logic w_timeout;

    assign w_accept  = ex_valid && (r_state == S_IDLE);
    assign w_is_mem  = ctl_mem_read || ctl_mem_write;
    assign w_misal   = (outE[1:0] != 2'b00);
    assign w_timeout = (r_wait == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_wait          <= '0;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_is_load       <= 1'b0;
            r_rw            <= 1'b0;
            r_reg           <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_data       <= '0;
            r_wb_reg        <= '0;
            r_pc_src        <= 1'b0;
            r_branch_target <= '0;
            r_misalign      <= 1'b0;
            r_bus_err       <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_pc_src   <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem && !w_misal) begin
                            r_state      <= S_ACCESS;
                            r_wait       <= '0;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= ctl_mem_write;
                            r_dmem_addr  <= outE;
                            r_dmem_wdata <= data2D_E;
                            r_is_load    <= ctl_mem_read;
                            r_rw         <= ctl_reg_write;
                            r_reg        <= RegEscr1E;
                        end else begin
                            // Non-memory op, or a misaligned access that is dropped
                            r_wb_valid     <= 1'b1;
                            r_wb_data      <= outE;
                            r_wb_reg       <= RegEscr1E;
                            r_wb_reg_write <= ctl_reg_write && !ctl_branch && !w_is_mem;
                            r_misalign     <= w_is_mem;
                            if (ctl_branch && oZeroD && !w_is_mem) begin
                                r_pc_src        <= 1'b1;
                                r_branch_target <= salSum2E;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        r_state        <= S_IDLE;
                        r_dmem_req     <= 1'b0;
                        r_wait         <= '0;
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= r_is_load ? dmem_rdata : r_dmem_addr;
                        r_wb_reg       <= r_reg;
                        r_wb_reg_write <= r_is_load && r_rw;
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_dmem_req <= 1'b0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall         = (r_state != S_IDLE);
    assign pc_src        = r_pc_src;
    assign branch_target = r_branch_target;
    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_data       = r_wb_data;
    assign wb_reg        = r_wb_reg;
    assign misalign      = r_misalign;
    assign bus_err       = r_bus_err;

endmodule
